// File: rtl/uart_tx.sv
// uart_tx - byte-wide serial transmitter for the 3.125 MHz domain.
//
// Bytes enter a small FIFO over a valid/ready handshake. Each byte is sent as
// an 11-bit frame: start (0), 8 data bits MSB first, even parity (XOR of the
// data bits), stop (1). Every bit is held CLKS_PER_BIT clocks. When another
// byte is waiting at the end of a stop bit, the next start bit follows with
// no idle gap.
//
// Handshake: a byte on tx_data is taken on any rising edge where
// tx_valid && tx_ready. tx_ready is low only while the FIFO is full, and a
// write into a full FIFO is dropped even if a pop happens on the same edge;
// the upstream stage must hold tx_data/tx_valid until it sees tx_ready.
//
// Ports:
//   clk_3125   in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tx_data    in   [7:0] byte to send
//   tx_valid   in   write request
//   tx_ready   out  FIFO not full
//   tx         out  serial line, idles high, registered
//   tx_busy    out  high while a frame is on the line
//   tx_done    out  one-cycle pulse after the last stop-bit clock
//   fsm_state  out  [2:0] current FSM state encoding (debug)
module uart_tx #(
    parameter int CLKS_PER_BIT = 27,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic          frame_end;

    // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wr_en;
    logic          pop;
    logic          clk_last;
    logic [7:0]    head;
    logic          line_bit;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready   = !fifo_full;
    assign wr_en      = tx_valid && !fifo_full;
    assign clk_last   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign head       = mem[rd_ptr[AW-1:0]];
    assign fsm_state  = state;

    // A pop happens from IDLE, or at the final stop-bit clock so the next
    // start bit follows the stop bit directly.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && clk_last));

    always_ff @(posedge clk_3125) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Line level belonging to the state held during this cycle. tx and
    // tx_busy register it, so the line trails the state by one clock and
    // every bit still lasts exactly CLKS_PER_BIT clocks.
    always_comb begin
        line_bit = 1'b1;
        case (state)
            IDLE:    line_bit = 1'b1;
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift[7];
            PARITY:  line_bit = parity;
            STOP:    line_bit = 1'b1;
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            frame_end <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx        <= line_bit;
            tx_busy   <= (state != IDLE);
            // frame_end marks the last stop-bit clock of the state; the extra
            // stage lines tx_done up with the end of the stop bit on tx.
            frame_end <= (state == STOP) && clk_last;
            tx_done   <= frame_end;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift  <= head;
                        parity <= ^head;
                        state  <= START;
                    end
                end
                START: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        shift   <= {shift[6:0], 1'b0};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        if (pop) begin
                            shift  <= head;
                            parity <= ^head;
                            state  <= START;
                        end else begin
                            state  <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: reset state, table of single-byte frames, a five-byte
// burst, reset mid-frame, and a write landing on the stop-to-start pop.
module tb_uart_tx;

  logic       clk_3125;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fsm_state;

  uart_tx #(.CLKS_PER_BIT(27), .FIFO_DEPTH(4)) dut (
    .clk_3125  (clk_3125),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk_3125 = 1'b0;
  always #160 clk_3125 = ~clk_3125;

  int pos_cyc = 0;
  always @(posedge clk_3125) pos_cyc <= pos_cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [10:0] frame_q[$];
  int          start_q[$];
  int          done_q[$];
  logic        busy_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- line monitor / loopback receiver ----------------
  // Samples tx mid-bit (clock 13 of 27) and records start/done timestamps.
  initial begin
    bit          mon_active;
    int          mon_k;
    logic [10:0] mon_fr;
    mon_active = 0;
    mon_k      = 0;
    mon_fr     = '0;
    forever begin
      @(negedge clk_3125);
      if (tx_done === 1'b1) done_q.push_back(pos_cyc);
      if (rst !== 1'b0) begin
        mon_active = 0;
      end else if (mon_active) begin
        mon_k++;
        if (mon_k % 27 == 13) begin
          mon_fr = {mon_fr[9:0], tx};
          if (mon_k == 13) busy_q.push_back(tx_busy);
        end
        if (mon_k == 283) begin
          frame_q.push_back(mon_fr);
          mon_active = 0;
        end
      end else if (tx === 1'b0) begin
        mon_active = 1;
        mon_k      = 0;
        start_q.push_back(pos_cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] d, output int acc);
    int w;
    tx_data  = d;
    tx_valid = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk_3125);
      w++;
    end
    if (w >= 2000) chk("push_ready_timeout", 32'(w), 32'd0);
    @(negedge clk_3125);
    acc      = pos_cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int w;
    w = 0;
    while (done_q.size() < n && w < budget) begin
      @(negedge clk_3125);
      w++;
    end
    repeat (2) @(negedge clk_3125);
    chk(nm, 32'(done_q.size()), 32'(n));
  endtask

  task automatic clear_sb();
    frame_q.delete();
    start_q.delete();
    done_q.delete();
    busy_q.delete();
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic [10:0] frame;   // start, d7..d0, parity, stop
  } vec_t;

  vec_t vecs[6];
  vec_t hello[5];
  vec_t simul[6];

  initial begin
    int acc, acc1, acc5, bad, s, w;
    logic [10:0] fr;

    vecs[0] = '{8'h41, 1'b0, 11'b0_0100_0001_0_1};
    vecs[1] = '{8'h07, 1'b1, 11'b0_0000_0111_1_1};
    vecs[2] = '{8'hFF, 1'b0, 11'b0_1111_1111_0_1};
    vecs[3] = '{8'h00, 1'b0, 11'b0_0000_0000_0_1};
    vecs[4] = '{8'h80, 1'b1, 11'b0_1000_0000_1_1};
    vecs[5] = '{8'h5A, 1'b0, 11'b0_0101_1010_0_1};

    hello[0] = '{8'h48, 1'b0, 11'b0_0100_1000_0_1};
    hello[1] = '{8'h45, 1'b1, 11'b0_0100_0101_1_1};
    hello[2] = '{8'h4C, 1'b1, 11'b0_0100_1100_1_1};
    hello[3] = '{8'h4C, 1'b1, 11'b0_0100_1100_1_1};
    hello[4] = '{8'h4F, 1'b1, 11'b0_0100_1111_1_1};

    simul[0] = '{8'h3C, 1'b0, 11'b0_0011_1100_0_1};
    simul[1] = '{8'hC3, 1'b0, 11'b0_1100_0011_0_1};
    simul[2] = '{8'h96, 1'b0, 11'b0_1001_0110_0_1};
    simul[3] = '{8'h01, 1'b1, 11'b0_0000_0001_1_1};
    simul[4] = '{8'h02, 1'b1, 11'b0_0000_0010_1_1};
    simul[5] = '{8'h03, 1'b0, 11'b0_0000_0011_0_1};

    // ---------------- reset ----------------
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk_3125);
    @(negedge clk_3125);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    chk("idle_500_bad_cycles", 32'(bad), 32'd0);
    chk("idle_500_frames", 32'(start_q.size()), 32'd0);

    // ---------------- table: single frames ----------------
    for (int i = 0; i < 6; i++) begin
      clear_sb();
      push(vecs[i].data, acc);
      wait_done(1, 400, $sformatf("vec%0d_done_count", i));
      if (frame_q.size() > 0 && start_q.size() > 0 && done_q.size() > 0 && busy_q.size() > 0) begin
        fr = frame_q.pop_front();
        s  = start_q.pop_front();
        chk($sformatf("vec%0d_frame", i), 32'(fr), 32'(vecs[i].frame));
        chk($sformatf("vec%0d_rx_data", i), 32'(fr[9:2]), 32'(vecs[i].data));
        chk($sformatf("vec%0d_rx_parity", i), 32'(fr[1]), 32'(vecs[i].par));
        chk($sformatf("vec%0d_latency", i), 32'(s - acc), 32'd2);
        chk($sformatf("vec%0d_done_time", i), 32'(done_q.pop_front() - s), 32'd297);
        chk($sformatf("vec%0d_busy_mid", i), 32'(busy_q.pop_front()), 32'd1);
      end else begin
        chk($sformatf("vec%0d_frame_missing", i), 32'(frame_q.size()), 32'd1);
      end
      chk($sformatf("vec%0d_busy_after", i), 32'(tx_busy), 32'd0);
      chk($sformatf("vec%0d_done_low_after", i), 32'(tx_done), 32'd0);
      chk($sformatf("vec%0d_tx_idle", i), 32'(tx), 32'd1);
      repeat (5) @(negedge clk_3125);
    end

    // ---------------- burst: HELLO ----------------
    clear_sb();
    acc1 = 0;
    acc5 = 0;
    for (int i = 0; i < 5; i++) begin
      push(hello[i].data, acc);
      if (i == 0) acc1 = acc;
      if (i == 3) chk("hello_ready_after_4th", 32'(tx_ready), 32'd1);
      if (i == 4) acc5 = acc;
    end
    chk("hello_ready_full", 32'(tx_ready), 32'd0);
    chk("hello_5th_accept_edge", 32'(acc5 - acc1), 32'd4);
    wait_done(5, 5 * 297 + 100, "hello_done_count");
    chk("hello_frame_count", 32'(frame_q.size()), 32'd5);
    chk("hello_start_count", 32'(start_q.size()), 32'd5);
    if (frame_q.size() == 5 && start_q.size() == 5 && done_q.size() == 5) begin
      chk("hello_first_latency", 32'(start_q[0] - acc1), 32'd2);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("hello%0d_frame", i), 32'(frame_q[i]), 32'(hello[i].frame));
        chk($sformatf("hello%0d_done_time", i), 32'(done_q[i] - start_q[i]), 32'd297);
        if (i > 0) chk($sformatf("hello%0d_spacing", i), 32'(start_q[i] - start_q[i-1]), 32'd297);
      end
    end
    chk("hello_ready_after", 32'(tx_ready), 32'd1);
    repeat (5) @(negedge clk_3125);

    // ---------------- reset mid-frame ----------------
    clear_sb();
    push(8'h55, acc);
    push(8'hAA, acc);
    w = 0;
    while (start_q.size() == 0 && w < 50) begin
      @(negedge clk_3125);
      w++;
    end
    chk("rstmid_started", 32'(start_q.size()), 32'd1);
    s = (start_q.size() > 0) ? start_q[0] : pos_cyc;
    w = 0;
    while (pos_cyc < s + 149 && w < 400) begin
      @(negedge clk_3125);
      w++;
    end
    chk("rstmid_tx_before", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk_3125);
    chk("rstmid_tx", 32'(tx), 32'd1);
    chk("rstmid_busy", 32'(tx_busy), 32'd0);
    chk("rstmid_ready", 32'(tx_ready), 32'd1);
    chk("rstmid_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("rstmid_line_quiet", 32'(bad), 32'd0);
    chk("rstmid_no_done", 32'(done_q.size()), 32'd0);
    chk("rstmid_no_frame", 32'(frame_q.size()), 32'd0);
    chk("rstmid_no_new_start", 32'(start_q.size()), 32'd1);

    // ---------------- write coinciding with stop-to-start pop ----------------
    clear_sb();
    push(simul[0].data, acc);
    push(simul[1].data, acc);
    w = 0;
    while (start_q.size() == 0 && w < 50) begin
      @(negedge clk_3125);
      w++;
    end
    s = (start_q.size() > 0) ? start_q[0] : pos_cyc;
    w = 0;
    while (pos_cyc < s + 295 && w < 400) begin
      @(negedge clk_3125);
      w++;
    end
    push(simul[2].data, acc);
    chk("simul_write_on_pop_edge", 32'(acc - s), 32'd296);
    chk("simul_ready_after_c", 32'(tx_ready), 32'd1);
    push(simul[3].data, acc);
    push(simul[4].data, acc);
    chk("simul_ready_occ3", 32'(tx_ready), 32'd1);
    push(simul[5].data, acc);
    chk("simul_ready_occ4", 32'(tx_ready), 32'd0);
    wait_done(6, 6 * 297 + 100, "simul_done_count");
    chk("simul_frame_count", 32'(frame_q.size()), 32'd6);
    if (frame_q.size() == 6 && start_q.size() == 6 && done_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("simul%0d_frame", i), 32'(frame_q[i]), 32'(simul[i].frame));
        chk($sformatf("simul%0d_done_time", i), 32'(done_q[i] - start_q[i]), 32'd297);
        if (i > 0) chk($sformatf("simul%0d_spacing", i), 32'(start_q[i] - start_q[i-1]), 32'd297);
      end
    end
    chk("simul_busy_end", 32'(tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound in case a wait loop is defeated.
  initial begin
    #(320 * 60000);
    $display("FAIL global_timeout: got %0d cycles expected completion", pos_cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter feeding `uart_rx` on the 3.125 MHz clock domain: accepts bytes over a valid/ready handshake into a small FIFO and emits 11-bit frames on `tx`. Frames are one start bit (0), 8 data bits MSB first, one even-parity bit (XOR of the data bits), and one stop bit (1), each held 27 clocks, so each frame is 297 clocks. Frame format and bit timing are the exact complement of `uart_rx`, so `tx` may drive `rx` directly for loopback.

## Interface
- `CLKS_PER_BIT`, 27, clocks per serial bit (3.125 MHz / 115200 baud).
- `FIFO_DEPTH`, 4, byte FIFO entries; power of two, at least 2.
- `clk_3125`  input  1  system clock, 3.125 MHz, all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  input  1  write request.
- `tx_ready`  output  1  high when the FIFO is not full.
- `tx`  output  1  serial line; idles high.
- `tx_busy`  output  1  high while a frame is on the line (START through STOP).
- `tx_done`  output  1  one-cycle pulse after the last stop-bit clock of each frame.

## Operation
- One clock domain; reset is synchronous and active-high.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, FIFO empty, FSM in IDLE, bit counter 0, clock counter 0.
- FIFO write: a byte is accepted on an edge where `tx_valid && tx_ready`. When full, `tx_valid` is ignored and the byte is not stored; the upstream stage must hold it.
- FIFO pointers use log2(FIFO_DEPTH)+1 bits. Full and empty come from the MSB comparison, and the pointers wrap modulo 2·FIFO_DEPTH.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If the FIFO is not empty, pop the head into the shift register, latch parity = ^byte, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: `tx`=shift[7], shifting left every CLKS_PER_BIT clocks. After the 8th bit, go to PARITY.
  - PARITY: `tx`=latched parity for CLKS_PER_BIT clocks, then go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT clocks. At its final clock, pulse `tx_done`. If the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- `tx` is a registered output and never glitches.
- Simultaneous write and pop in one cycle are both performed; occupancy is unchanged. A write into a full FIFO is rejected even if a pop occurs in the same cycle.
- Asserting `rst` mid-frame: on the next edge `tx`=1, the FSM returns to IDLE, and the FIFO is cleared. No `tx_done` pulse is emitted for the aborted frame.

## Timing
- Latency: a write accepted at edge N into an idle, empty block pops at edge N+1. The start bit appears on `tx` from edge N+2 (registered output).
- Each bit is exactly CLKS_PER_BIT clocks. A frame is 11·CLKS_PER_BIT = 297 clocks from the start-bit edge to the end of the stop bit.
- `tx_busy` rises with the start bit and falls on the same edge `tx_done` rises, unless back-to-back.
- Back-to-back frames: the next start edge occurs exactly 297 clocks after the previous start edge. `tx_busy` stays high and `tx_done` still pulses once per frame.
- `tx_ready` reflects FIFO state after the current edge's write and pop. It drops the cycle after the FIFO becomes full and rises the cycle after a pop frees a slot.

## Test plan
- Reset check: hold `rst` 3 cycles, release. Required: `tx`=1, `tx_ready`=1, `tx_busy`=0, and `tx_done`=0 for 500 clocks with no writes.
- Single byte 0x41 ('A'): `tx` shows 0, then 0,1,0,0,0,0,0,1, then parity 0, then stop 1, each 27 clocks. `tx_done` pulses once, 297 clocks after the start edge.
- Byte 0x07: parity bit = 1. Looped back into `uart_rx`, the receiver gives `rx_msg`=0x07, `rx_parity`=1, and `rx_complete` pulses.
- Burst of 5 writes ("HELLO" = 0x48,0x45,0x4C,0x4C,0x4F) with `tx_valid` held high:
  - `tx_ready` drops once 4 bytes are buffered, and the 5th byte is accepted only after the first pop.
  - The 5 frames are contiguous, with start edges spaced exactly 297 clocks apart.
  - Exactly 5 `tx_done` pulses occur, and the loopback receiver gives "HELLO".
- Reset mid-frame: write 0x55 and 0xAA, then assert `rst` at clock 150 of the first frame. Required: `tx`=1 on the next edge, FIFO empty, no `tx_done`, and no further frames.
- Simultaneous write and pop: with 1 byte queued, time a write to coincide with the STOP-to-START pop. Required: the byte is stored, occupancy stays 1, and the next frame carries it.
